// File: rtl/vga_scanout_if.sv
// Framebuffer read port and video output bundle for vga_scanout.
// master: the scanout block (drives address and video, reads pixel data).
// slave : the framebuffer / display side.
interface vga_scanout_if #(
  parameter int ADDR_WIDTH = 17
);
  logic [ADDR_WIDTH-1:0] fb_addr;
  logic [7:0]            fb_data;
  logic                  hsync;
  logic                  vsync;
  logic [3:0]            red;
  logic [3:0]            green;
  logic [3:0]            blue;
  logic                  de;
  logic                  frame_start;

  modport master (
    output fb_addr,
    input  fb_data,
    output hsync, vsync, red, green, blue, de, frame_start
  );

  modport slave (
    input  fb_addr,
    output fb_data,
    input  hsync, vsync, red, green, blue, de, frame_start
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout: raster timing from a divided system clock, 2x2-upscaled
// framebuffer fetch and RGB332 -> RGB444 expansion. Every video output is
// registered on the pixel tick, so all of them lag the raster counters by
// exactly one pixel period and stay mutually aligned.
module vga_scanout #(
  parameter int ADDR_WIDTH = 17,
  parameter int CLK_DIV    = 4,
  parameter int RD_LATENCY = 1,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33
) (
  input  logic          clk,
  input  logic          rst,
  vga_scanout_if.master io_vid
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FB_W    = H_VISIBLE / 2;

  // Read data is sampled CLK_DIV-1 cycles after the address settles.
  if (RD_LATENCY > CLK_DIV - 1) begin : g_bad_latency
    $error("vga_scanout: RD_LATENCY must be <= CLK_DIV-1");
  end

  // Channel expansion: replicate the MSBs into the freed LSBs so that
  // full-scale input maps to full-scale output (7 -> 15, 3 -> 15).
  function automatic logic [3:0] expand3(input logic [2:0] c);
    return {c, c[2]};
  endfunction

  function automatic logic [3:0] expand2(input logic [1:0] c);
    return {c, c};
  endfunction

  logic [DIV_W-1:0] r_div_p0;
  logic [HC_W-1:0]  r_hcnt_p0;
  logic [VC_W-1:0]  r_vcnt_p0;

  logic             r_hsync_p1;
  logic             r_vsync_p1;
  logic             r_de_p1;
  logic [3:0]       r_red_p1;
  logic [3:0]       r_green_p1;
  logic [3:0]       r_blue_p1;
  logic             r_frame_start_p1;

  logic                  w_pix_tick;
  logic                  w_visible;
  logic                  w_hsync_act;
  logic                  w_vsync_act;
  logic                  w_fs_pos;
  logic [HC_W-2:0]       w_x;
  logic [VC_W-2:0]       w_y;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_pix_tick  = (r_div_p0 == DIV_W'(CLK_DIV - 1));
  assign w_visible   = (r_hcnt_p0 < HC_W'(H_VISIBLE)) && (r_vcnt_p0 < VC_W'(V_VISIBLE));
  assign w_hsync_act = (r_hcnt_p0 >= HC_W'(H_VISIBLE + H_FRONT)) &&
                       (r_hcnt_p0 <  HC_W'(H_VISIBLE + H_FRONT + H_SYNC));
  assign w_vsync_act = (r_vcnt_p0 >= VC_W'(V_VISIBLE + V_FRONT)) &&
                       (r_vcnt_p0 <  VC_W'(V_VISIBLE + V_FRONT + V_SYNC));
  assign w_fs_pos    = (r_hcnt_p0 == '0) && (r_vcnt_p0 == VC_W'(V_VISIBLE));

  // Stored image is half resolution in both axes: drop the counter LSBs.
  // With FB_W = 320 the constant multiply reduces to (y<<8)+(y<<6).
  assign w_x    = r_hcnt_p0[HC_W-1:1];
  assign w_y    = r_vcnt_p0[VC_W-1:1];
  assign w_addr = w_visible ? (ADDR_WIDTH'(w_y) * ADDR_WIDTH'(FB_W) + ADDR_WIDTH'(w_x))
                            : '0;

  // Stage p0: pixel clock divider and raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_p0  <= '0;
      r_hcnt_p0 <= '0;
      r_vcnt_p0 <= '0;
    end else begin
      r_div_p0 <= w_pix_tick ? '0 : r_div_p0 + 1'b1;
      if (w_pix_tick) begin
        if (r_hcnt_p0 == HC_W'(H_TOTAL - 1)) begin
          r_hcnt_p0 <= '0;
          r_vcnt_p0 <= (r_vcnt_p0 == VC_W'(V_TOTAL - 1)) ? '0 : r_vcnt_p0 + 1'b1;
        end else begin
          r_hcnt_p0 <= r_hcnt_p0 + 1'b1;
        end
      end
    end
  end

  // Stage p1: register sync/visible decodes and expanded pixel on each tick
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync_p1       <= 1'b1;
      r_vsync_p1       <= 1'b1;
      r_de_p1          <= 1'b0;
      r_red_p1         <= '0;
      r_green_p1       <= '0;
      r_blue_p1        <= '0;
      r_frame_start_p1 <= 1'b0;
    end else begin
      r_frame_start_p1 <= 1'b0;
      if (w_pix_tick) begin
        r_hsync_p1       <= ~w_hsync_act;
        r_vsync_p1       <= ~w_vsync_act;
        r_de_p1          <= w_visible;
        r_red_p1         <= w_visible ? expand3(io_vid.fb_data[7:5]) : 4'h0;
        r_green_p1       <= w_visible ? expand3(io_vid.fb_data[4:2]) : 4'h0;
        r_blue_p1        <= w_visible ? expand2(io_vid.fb_data[1:0]) : 4'h0;
        r_frame_start_p1 <= w_fs_pos;
      end
    end
  end

  assign io_vid.fb_addr     = w_addr;
  assign io_vid.hsync       = r_hsync_p1;
  assign io_vid.vsync       = r_vsync_p1;
  assign io_vid.de          = r_de_p1;
  assign io_vid.red         = r_red_p1;
  assign io_vid.green       = r_green_p1;
  assign io_vid.blue        = r_blue_p1;
  assign io_vid.frame_start = r_frame_start_p1;

endmodule
